fifo_wr_arb: RTL and testbench

Round-robin write-port arbiter that shares one FIFO write interface among N requesting sources. Each source asks for a burst of a declared length. The arbiter grants one source at a time and streams that source's words into the FIFO with `wrreq`/`data`, stalling whenever `wrfull` is high. It sits between the data producers and the FIFO write side and replaces per-source FIFO write logic.

---
 rtl/fifo_wr_arb.sv | 94 +++++++++
 tb/tb_fifo_wr_arb.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter that shares one FIFO write port among N burst sources.
// Grants one source at a time and streams its words, stalling on wrfull.
//
// state | meaning
// IDLE  | no grant active; arbitrate among requesters starting at ptr
// BURST | granted source streams cnt+1 remaining words, stalled by wrfull
module fifo_wr_arb #(
  parameter int N  = 4,
  parameter int DW = 8,
  parameter int LW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    src_req,
  input  logic [N*LW-1:0] src_len,
  input  logic [N*DW-1:0] src_data,
  input  logic            wrfull,
  output logic [N-1:0]    src_gnt,
  output logic [N-1:0]    src_ack,
  output logic            wrreq,
  output logic [DW-1:0]   data,
  output logic            busy,
  output logic            burst_done
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] gnt_idx, ptr, win_idx, ptr_nxt, cand;
  logic [LW-1:0] cnt;
  logic          win_vld, take, last;

  // Scan from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      cand = IW'((int'(ptr) + i) % N);
      if (src_req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  assign take    = (state == BURST) && !wrfull;
  assign last    = take && (cnt == '0);
  assign ptr_nxt = IW'((int'(gnt_idx) + 1) % N);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      src_gnt <= '0;
      gnt_idx <= '0;
      ptr     <= '0;
      cnt     <= '0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == BURST);
      if (state == IDLE && win_vld) begin
        src_gnt <= N'(1) << win_idx;
        gnt_idx <= win_idx;
        cnt     <= src_len[int'(win_idx)*LW +: LW];
      end else if (last) begin
        src_gnt <= '0;
        ptr     <= ptr_nxt;
      end else if (take) begin
        cnt <= cnt - LW'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_vld) state_nxt = BURST;
      BURST:   if (last)    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    wrreq      = take;
    src_ack    = src_gnt & {N{take}};
    burst_done = last;
    data       = '0;
    if (state == BURST) data = src_data[int'(gnt_idx)*DW +: DW];
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Bench for fifo_wr_arb: vector table, directed corner sequences and a
// randomized run checked against a burst-level reference model.
module tb_fifo_wr_arb;
  localparam int N = 4, DW = 8, LW = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic [N-1:0]    src_req;
  logic [N*LW-1:0] src_len;
  logic [N*DW-1:0] src_data;
  logic            wrfull;
  logic [N-1:0]    src_gnt, src_ack;
  logic            wrreq, busy, burst_done;
  logic [DW-1:0]   data;

  int n_chk = 0, n_fail = 0;
  logic clr;
  logic [7:0] widx [N];

  always #5 clk = ~clk;

  fifo_wr_arb #(.N(N), .DW(DW), .LW(LW)) dut (
    .clk(clk), .rst_n(rst_n), .src_req(src_req), .src_len(src_len),
    .src_data(src_data), .wrfull(wrfull), .src_gnt(src_gnt), .src_ack(src_ack),
    .wrreq(wrreq), .data(data), .busy(busy), .burst_done(burst_done)
  );

  // Source emulation: word k of source s is base(s)+k, advancing on each ack.
  function automatic logic [7:0] base(input int s);
    return 8'((s + 1) * 16);
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < N; k++)
      if (clr) widx[k] <= 8'h00;
      else if (src_ack[k]) widx[k] <= widx[k] + 8'h01;
  end

  always_comb begin
    src_data = '0;
    for (int k = 0; k < N; k++) src_data[k*DW +: DW] = base(k) + widx[k];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; clr = 1'b1; src_req = '0; wrfull = 1'b0;
    #1;
    chk("rst_gnt", 32'(src_gnt), 32'h0);
    chk("rst_out", 32'({busy, wrreq, data, src_ack, burst_done}), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1; clr = 1'b0;
  endtask

  task automatic wait_grant(output logic [3:0] g);
    g = '0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1; @(negedge clk);
      if (src_gnt != '0) begin
        g = src_gnt;
        break;
      end
    end
  endtask

  typedef struct {
    bit pre_rst; logic [3:0] req; logic [7:0] len; logic wf;
    logic [3:0] gnt; logic [3:0] ack; logic wrreq; logic [7:0] data; logic done; logic busy;
  } vec_t;
  vec_t vt[$];

  function automatic vec_t mk(bit pr, logic [3:0] rq, logic [7:0] ln, logic wf, logic [3:0] g,
                              logic [3:0] a, logic w, logic [7:0] d, logic dn, logic b);
    vec_t v;
    v.pre_rst = pr; v.req = rq; v.len = ln; v.wf = wf; v.gnt = g; v.ack = a;
    v.wrreq = w; v.data = d; v.done = dn; v.busy = b;
    return v;
  endfunction

  task automatic run_table();
    // Source 0, four-word burst
    vt.push_back(mk(1, 4'b0001, 8'd3, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 0));
    vt.push_back(mk(0, 4'b0000, 8'd3, 0, 4'b0001, 4'b0001, 1, 8'h10, 0, 1));
    vt.push_back(mk(0, 4'b0000, 8'd3, 0, 4'b0001, 4'b0001, 1, 8'h11, 0, 1));
    vt.push_back(mk(0, 4'b0000, 8'd3, 0, 4'b0001, 4'b0001, 1, 8'h12, 0, 1));
    vt.push_back(mk(0, 4'b0000, 8'd3, 0, 4'b0001, 4'b0001, 1, 8'h13, 1, 1));
    vt.push_back(mk(0, 4'b0000, 8'd3, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 0));
    // All sources, length 0: grant order 0,1,2,3,0,1 with an idle cycle between
    vt.push_back(mk(1, 4'b1111, 8'd0, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 0));
    vt.push_back(mk(0, 4'b1111, 8'd0, 0, 4'b0001, 4'b0001, 1, 8'h10, 1, 1));
    vt.push_back(mk(0, 4'b1111, 8'd0, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 0));
    vt.push_back(mk(0, 4'b1111, 8'd0, 0, 4'b0010, 4'b0010, 1, 8'h20, 1, 1));
    vt.push_back(mk(0, 4'b1111, 8'd0, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 0));
    vt.push_back(mk(0, 4'b1111, 8'd0, 0, 4'b0100, 4'b0100, 1, 8'h30, 1, 1));
    vt.push_back(mk(0, 4'b1111, 8'd0, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 0));
    vt.push_back(mk(0, 4'b1111, 8'd0, 0, 4'b1000, 4'b1000, 1, 8'h40, 1, 1));
    vt.push_back(mk(0, 4'b1111, 8'd0, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 0));
    vt.push_back(mk(0, 4'b1111, 8'd0, 0, 4'b0001, 4'b0001, 1, 8'h11, 1, 1));
    vt.push_back(mk(0, 4'b1111, 8'd0, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 0));
    vt.push_back(mk(0, 4'b1111, 8'd0, 0, 4'b0010, 4'b0010, 1, 8'h21, 1, 1));
    foreach (vt[i]) begin
      if (vt[i].pre_rst) do_reset();
      src_req = vt[i].req; src_len = {N{vt[i].len}}; wrfull = vt[i].wf;
      @(negedge clk);
      chk($sformatf("vec%0d_gnt", i),   32'(src_gnt),    32'(vt[i].gnt));
      chk($sformatf("vec%0d_ack", i),   32'(src_ack),    32'(vt[i].ack));
      chk($sformatf("vec%0d_wrreq", i), 32'(wrreq),      32'(vt[i].wrreq));
      chk($sformatf("vec%0d_data", i),  32'(data),       32'(vt[i].data));
      chk($sformatf("vec%0d_done", i),  32'(burst_done), 32'(vt[i].done));
      chk($sformatf("vec%0d_busy", i),  32'(busy),       32'(vt[i].busy));
      @(posedge clk); #1;
    end
  endtask

  task automatic run_stall();
    int writes = 0, stalls = 0, gcyc = 0, dones = 0;
    do_reset();
    src_len = {N{8'd7}}; src_req = 4'b0100;
    for (int c = 0; c < 20; c++) begin
      wrfull = (writes == 3 && stalls < 3);
      @(negedge clk);
      if (src_gnt != '0) gcyc++;
      if (wrfull) begin
        stalls++;
        chk("stall_wrreq", 32'(wrreq), 32'h0);
        chk("stall_ack", 32'(src_ack), 32'h0);
        chk("stall_data", 32'(data), 32'h33);
      end
      if (wrreq) begin
        chk("stall_burst_data", 32'(data), 32'h30 + 32'(writes));
        writes++;
      end
      if (burst_done) dones++;
      @(posedge clk); #1;
      src_req = '0;
    end
    wrfull = 1'b0;
    chk("stall_writes", 32'(writes), 32'd8);
    chk("stall_span", 32'(gcyc), 32'd11);
    chk("stall_dones", 32'(dones), 32'd1);
    chk("stall_count", 32'(stalls), 32'd3);
  endtask

  task automatic run_rr_and_reset();
    logic [3:0] g;
    do_reset();
    src_len = {N{8'd0}}; src_req = 4'b0010;
    wait_grant(g); chk("rr_first", 32'(g), 32'b0010);
    src_req = 4'b1010;
    wait_grant(g); chk("rr_second", 32'(g), 32'b1000);
    wait_grant(g); chk("rr_third", 32'(g), 32'b0010);
    // Reset asserted on word 2 of a six-word burst from source 1
    do_reset();
    src_len = {N{8'd5}}; src_req = 4'b0010;
    wait_grant(g); chk("mrst_gnt", 32'(g), 32'b0010);
    @(posedge clk); #1; @(posedge clk); #1; @(negedge clk);
    chk("mrst_word2", 32'(data), 32'h22);
    #1; rst_n = 1'b0; #1;
    chk("mrst_gnt0", 32'(src_gnt), 32'h0);
    chk("mrst_out0", 32'({busy, wrreq, data, src_ack, burst_done}), 32'h0);
    src_req = 4'b1111;
    @(posedge clk); #1; rst_n = 1'b1;
    wait_grant(g); chk("mrst_regrant", 32'(g), 32'b0001);
  endtask

  task automatic run_full_idle();
    logic [3:0] g;
    int w = 0, dones = 0;
    do_reset();
    wrfull = 1'b1; src_len = {N{8'd1}}; src_req = 4'b1000;
    wait_grant(g); chk("fidle_gnt", 32'(g), 32'b1000);
    chk("fidle_wrreq", 32'(wrreq), 32'h0);
    chk("fidle_busy", 32'(busy), 32'h1);
    src_req = '0;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1; @(negedge clk);
      chk("fidle_hold_wrreq", 32'(wrreq), 32'h0);
      chk("fidle_hold_gnt", 32'(src_gnt), 32'b1000);
    end
    @(posedge clk); #1; wrfull = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (wrreq) begin
        chk("fidle_data", 32'(data), 32'h40 + 32'(w));
        w++;
      end
      if (burst_done) dones++;
      @(posedge clk); #1;
    end
    chk("fidle_writes", 32'(w), 32'd2);
    chk("fidle_dones", 32'(dones), 32'd1);
  endtask

  // Burst-level model: owner, words left, rotation start, words consumed per source.
  task automatic run_random();
    int m_owner = -1, m_left = 0, m_ptr = 0;
    int m_cons [N];
    logic [18:0] exp;
    logic [3:0] g;
    logic tk;
    do_reset();
    for (int k = 0; k < N; k++) m_cons[k] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 3) == 0) src_req[k] = ~src_req[k];
        src_len[k*LW +: LW] = ($urandom_range(0, 99) == 0) ? 8'hFF : 8'($urandom_range(0, 3));
      end
      wrfull = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      if (m_owner < 0) exp = '0;
      else begin
        g  = 4'b0001 << m_owner;
        tk = !wrfull;
        exp = {g, tk ? g : 4'b0000, tk, 8'(base(m_owner) + 8'(m_cons[m_owner])),
               tk && (m_left == 1), 1'b1};
      end
      chk($sformatf("rand_cyc%0d", c), 32'({src_gnt, src_ack, wrreq, data, burst_done, busy}),
          32'(exp));
      if (m_owner < 0) begin
        for (int s = 0; s < N; s++) begin
          int k = (m_ptr + s) % N;
          if (src_req[k]) begin
            m_owner = k;
            m_left  = int'(src_len[k*LW +: LW]) + 1;
            break;
          end
        end
      end else if (!wrfull) begin
        m_cons[m_owner]++;
        m_left--;
        if (m_left == 0) begin
          m_ptr   = (m_owner + 1) % N;
          m_owner = -1;
        end
      end
      @(posedge clk); #1;
    end
    src_req = '0; wrfull = 1'b0;
  endtask

  initial begin
    src_req = '0; src_len = '0; wrfull = 1'b0; clr = 1'b1; rst_n = 1'b0;
    do_reset();
    run_table();
    run_stall();
    run_rr_and_reset();
    run_full_idle();
    run_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
